rv32_load_store_unit: RTL and testbench
=======================================

RV32_LOAD_STORE_UNIT -- requirements
Module: rv32_load_store_unit

Interface
REQ-001 SHALL have parameter: ERR_RDATA, 32'h0000_0000, value driven on resp_rdata with any error response.
REQ-002 SHALL have port: clk  input  1  clock; all state changes on posedge.
REQ-003 SHALL have port: rst  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port: req_valid  input  1  core presents a load/store request.
REQ-005 SHALL have port: req_ready  output  1  LSU accepts a request this cycle.
REQ-006 SHALL have port: req_write  input  1  1=store, 0=load.
REQ-007 SHALL have port: req_funct3  input  3  RV32I funct3 (LB/LH/LW/LBU/LHU, SB/SH/SW).
REQ-008 SHALL have port: req_addr  input  32  byte address.
REQ-009 SHALL have port: req_wdata  input  32  store data, using low byte/half/word.
REQ-010 SHALL have port: resp_valid  output  1  one-cycle completion pulse.
REQ-011 SHALL have port: resp_rdata  output  32  extended load result; 0 for stores.
REQ-012 SHALL have port: resp_error  output  1  qualified by resp_valid; misaligned or illegal funct3.
REQ-013 SHALL have ports: mem_addr output 32, mem_wr_data output 32, mem_wr_ena output 1, mem_rd_data input 32; word-only memory with rd_data valid the cycle after mem_addr is driven.

Function
REQ-014 SHALL implement states IDLE, READ, MERGE, WRITE, RESP.
REQ-015 SHALL drive req_ready=1 only in IDLE with rst low; a request is accepted on the posedge where req_valid&req_ready, latching write, funct3, addr and wdata.
REQ-016 SHALL drive mem_addr={addr[31:2],2'b00} from the latched address in READ/MERGE/WRITE; 0 otherwise.
REQ-017 Load: IDLE->READ->RESP->IDLE; resp_valid asserted two cycles after the accept edge.
REQ-018 SHALL, in RESP for loads, extract the lane from the word read in READ: LB/LBU byte addr[1:0], LH/LHU half addr[1]; LB/LH sign-extend, LBU/LHU zero-extend, LW pass-through.
REQ-019 SW: IDLE->WRITE->RESP; mem_wr_ena=1 for exactly the WRITE cycle with mem_wr_data=wdata.
REQ-020 SB/SH: IDLE->READ->MERGE->WRITE->RESP; MERGE registers read word with the selected lane replaced by wdata[7:0]/wdata[15:0]; WRITE writes it; other lanes unchanged.
REQ-021 Illegal funct3 (load 3'b011/110/111, store >=3'b011) SHALL go IDLE->RESP, resp_error=1, resp_rdata=ERR_RDATA, no memory access.
REQ-022 mem_wr_ena SHALL be 0 in every state except WRITE, and SHALL be 0 combinationally whenever rst=1.
REQ-023 resp_valid SHALL be 1 only in RESP, for one cycle; RESP->IDLE unconditionally.
REQ-024 req_valid while req_ready=0 SHALL be ignored; no queuing.
REQ-025 Load of address X issued immediately after a store to X SHALL return the stored value (memory write completes before READ).

Reset
REQ-026 On rst: state=IDLE, latched request=0; outputs req_ready=0, resp_valid=0, resp_error=0, resp_rdata=0, mem_addr=0, mem_wr_data=0, mem_wr_ena=0.
REQ-027 rst asserted in any state including WRITE SHALL abort the operation; no write occurs in that cycle and no response is issued.
REQ-028 req_ready SHALL be 1 the first cycle after rst deasserts.

Configuration
REQ-029 SHALL support macro LSU_ALIGN_CHECK_EN.
REQ-030 With LSU_ALIGN_CHECK_EN defined: LH/LHU/SH with addr[0]=1 or LW/SW with addr[1:0]!=0 SHALL go IDLE->RESP with resp_error=1, resp_rdata=ERR_RDATA, no memory access.
REQ-031 Without it: no misalignment error; halfword uses addr[1], word ignores addr[1:0], byte lanes per REQ-018/020.

Verification
REQ-032 Mem[0x10]=0x8899AABB; LB 0x11 -> resp_rdata=0xFFFFFFAA at accept+2, resp_error=0; LBU 0x11 -> 0x000000AA.
REQ-033 Mem[0x20]=0x11223344; SH wdata=0xDEADBEEF addr 0x22 -> single write 0xBEEF3344, resp_valid at accept+4; then LW 0x20 -> 0xBEEF3344.
REQ-034 LW 0x13 with LSU_ALIGN_CHECK_EN -> resp_error=1, resp_rdata=0, mem_wr_ena never 1; without macro -> word at 0x10, resp_error=0.
REQ-035 Load funct3=3'b111 -> resp_error=1 at accept+1; req_valid held high during busy cycles -> no extra accepts.
REQ-036 rst asserted during WRITE of SW 0x30=0x12345678 -> mem_wr_ena=0 that cycle, Mem[0x30] unchanged, no resp_valid, req_ready=1 after rst drops.

Source files
------------

// File: rtl/rv32_load_store_unit.sv
// RV32I load/store unit between the core and a word-only synchronous memory.
// Optional macro LSU_ALIGN_CHECK_EN turns misaligned half/word accesses into error responses.
module rv32_load_store_unit #(
    parameter logic [31:0] ERR_RDATA = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_error,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wr_data,
    output logic        mem_wr_ena,
    input  logic [31:0] mem_rd_data
);

    typedef enum logic [2:0] {
        IDLE,
        READ,
        MERGE,
        WRITE,
        RESP
    } state_t;

    state_t      state;
    logic        write_q;
    logic [2:0]  funct3_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic        err_q;

    logic        req_legal;
    logic        req_misaligned;

    // Pick the addressed lane out of a memory word and extend it to 32 bits.
    function automatic logic [31:0] load_extract(input logic [2:0]  f3,
                                                 input logic [1:0]  lane,
                                                 input logic [31:0] word);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] result;
        case (lane)
            2'd0:    b = word[7:0];
            2'd1:    b = word[15:8];
            2'd2:    b = word[23:16];
            default: b = word[31:24];
        endcase
        h = lane[1] ? word[31:16] : word[15:0];
        case (f3)
            3'b000:  result = {{24{b[7]}}, b};
            3'b001:  result = {{16{h[15]}}, h};
            3'b100:  result = {24'h000000, b};
            3'b101:  result = {16'h0000, h};
            default: result = word;
        endcase
        return result;
    endfunction

    // Replace only the addressed byte/half of the word with the store data.
    function automatic logic [31:0] store_merge(input logic [2:0]  f3,
                                                input logic [1:0]  lane,
                                                input logic [31:0] word,
                                                input logic [31:0] data);
        logic [31:0] result;
        result = word;
        if (f3 == 3'b000) begin
            case (lane)
                2'd0:    result[7:0]   = data[7:0];
                2'd1:    result[15:8]  = data[7:0];
                2'd2:    result[23:16] = data[7:0];
                default: result[31:24] = data[7:0];
            endcase
        end else if (lane[1]) begin
            result[31:16] = data[15:0];
        end else begin
            result[15:0] = data[15:0];
        end
        return result;
    endfunction

    always_comb begin
        req_legal      = 1'b0;
        req_misaligned = 1'b0;
        if (req_write) begin
            req_legal = (req_funct3 == 3'b000) || (req_funct3 == 3'b001) ||
                        (req_funct3 == 3'b010);
        end else begin
            req_legal = (req_funct3 == 3'b000) || (req_funct3 == 3'b001) ||
                        (req_funct3 == 3'b010) || (req_funct3 == 3'b100) ||
                        (req_funct3 == 3'b101);
        end
`ifdef LSU_ALIGN_CHECK_EN
        case (req_funct3[1:0])
            2'b01:   req_misaligned = req_addr[0];
            2'b10:   req_misaligned = (req_addr[1:0] != 2'b00);
            default: req_misaligned = 1'b0;
        endcase
`endif
    end

    // Full-word stores skip the read; byte/half stores read-modify-write,
    // reusing wdata_q as the merge buffer once the old word arrives.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            write_q  <= 1'b0;
            funct3_q <= 3'b000;
            addr_q   <= 32'h0;
            wdata_q  <= 32'h0;
            err_q    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        write_q  <= req_write;
                        funct3_q <= req_funct3;
                        addr_q   <= req_addr;
                        wdata_q  <= req_wdata;
                        err_q    <= !req_legal || req_misaligned;
                        if (!req_legal || req_misaligned) begin
                            state <= RESP;
                        end else if (req_write && (req_funct3 == 3'b010)) begin
                            state <= WRITE;
                        end else begin
                            state <= READ;
                        end
                    end
                end
                READ:  state <= write_q ? MERGE : RESP;
                MERGE: begin
                    wdata_q <= store_merge(funct3_q, addr_q[1:0], mem_rd_data, wdata_q);
                    state   <= WRITE;
                end
                WRITE: state <= RESP;
                RESP:  state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // Outputs are decoded from registered state and forced low during reset,
    // so an abort in WRITE never reaches the memory.
    always_comb begin
        req_ready   = 1'b0;
        resp_valid  = 1'b0;
        resp_error  = 1'b0;
        resp_rdata  = 32'h0;
        mem_addr    = 32'h0;
        mem_wr_data = 32'h0;
        mem_wr_ena  = 1'b0;
        if (!rst) begin
            case (state)
                IDLE: req_ready = 1'b1;
                READ, MERGE: mem_addr = {addr_q[31:2], 2'b00};
                WRITE: begin
                    mem_addr    = {addr_q[31:2], 2'b00};
                    mem_wr_data = wdata_q;
                    mem_wr_ena  = 1'b1;
                end
                RESP: begin
                    resp_valid = 1'b1;
                    resp_error = err_q;
                    if (err_q) begin
                        resp_rdata = ERR_RDATA;
                    end else if (!write_q) begin
                        resp_rdata = load_extract(funct3_q, addr_q[1:0], mem_rd_data);
                    end
                end
                default: req_ready = 1'b0;
            endcase
        end
    end

endmodule

// File: tb/tb_rv32_load_store_unit.sv
// Self-checking bench for rv32_load_store_unit with a word memory and a byte-lane reference model.
`timescale 1ns/1ps
module tb_rv32_load_store_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_error;
    logic [31:0] mem_addr;
    logic [31:0] mem_wr_data;
    logic        mem_wr_ena;
    logic [31:0] mem_rd_data;

    logic [31:0] mem     [0:255];
    logic [31:0] ref_mem [0:255];
    logic        sync_mem = 1'b0;
    int          wr_count = 0;
    int          accepts  = 0;
    int          n_checks = 0;
    int          n_fail   = 0;

    typedef struct {
        logic        wr;
        logic [2:0]  f3;
        logic [31:0] a;
        logic [31:0] wd;
        int          elat;
        logic [31:0] erd;
        logic        eerr;
        int          enwr;
        string       name;
    } vec_t;

    always #5 clk = ~clk;

    rv32_load_store_unit dut (
        .clk         (clk),
        .rst         (rst),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_write   (req_write),
        .req_funct3  (req_funct3),
        .req_addr    (req_addr),
        .req_wdata   (req_wdata),
        .resp_valid  (resp_valid),
        .resp_rdata  (resp_rdata),
        .resp_error  (resp_error),
        .mem_addr    (mem_addr),
        .mem_wr_data (mem_wr_data),
        .mem_wr_ena  (mem_wr_ena),
        .mem_rd_data (mem_rd_data)
    );

    // Word memory: read data appears the cycle after the address; sync_mem loads the model image.
    always @(posedge clk) begin
        if (sync_mem) begin
            for (int i = 0; i < 256; i++) mem[i] <= ref_mem[i];
        end else if (mem_wr_ena) begin
            mem[mem_addr[9:2]] <= mem_wr_data;
            wr_count <= wr_count + 1;
        end
        mem_rd_data <= mem[mem_addr[9:2]];
    end

    always @(negedge clk) begin
        if (req_valid && req_ready) accepts <= accepts + 1;
    end

    // Reference: byte-addressed view of memory with RV32I size/sign rules.
    function automatic void model(input logic wr, input logic [2:0] f3,
                                  input logic [31:0] a, input logic [31:0] wd,
                                  output int lat, output logic [31:0] rd,
                                  output logic err, output int nwr);
        int          size;
        int          off;
        logic        legal;
        logic        mis;
        logic [31:0] word;
        logic [31:0] mask;
        logic [31:0] v;
        legal = wr ? (f3 <= 3'd2) : (f3 != 3'd3 && f3 != 3'd6 && f3 != 3'd7);
        size  = 1 << f3[1:0];
        mis   = 1'b0;
`ifdef LSU_ALIGN_CHECK_EN
        if (legal) mis = (a % size) != 0;
`endif
        if (!legal || mis) begin
            lat = 1; rd = 32'h0; err = 1'b1; nwr = 0;
            return;
        end
        err  = 1'b0;
        word = ref_mem[a[9:2]];
        off  = (size == 4) ? 0 : (size == 2) ? int'(a[1]) * 2 : int'(a[1:0]);
        mask = (size == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * size)) - 32'd1) << (8 * off);
        if (!wr) begin
            lat = 2; nwr = 0;
            v = (word & mask) >> (8 * off);
            if (!f3[2] && size < 4) v = 32'($signed(v << (32 - 8 * size)) >>> (32 - 8 * size));
            rd = v;
        end else begin
            lat = (size == 4) ? 2 : 4; nwr = 1; rd = 32'h0;
            ref_mem[a[9:2]] = (word & ~mask) | ((wd << (8 * off)) & mask);
        end
    endfunction

    task automatic load_memory();
        @(posedge clk); #1 sync_mem = 1'b1;
        @(posedge clk); #1 sync_mem = 1'b0;
    endtask

    // Drives one request and captures the response; lat=0 means none within the bound.
    task automatic issue(input logic wr, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] wd, input bit hold, output bit acc,
                         output int lat, output logic [31:0] rd, output logic err,
                         output int nwr);
        int w0;
        @(posedge clk); #1;
        req_write = wr; req_funct3 = f3; req_addr = a; req_wdata = wd; req_valid = 1'b1;
        acc = 1'b0; lat = 0; rd = 'x; err = 1'bx; nwr = 0;
        for (int i = 0; i < 10 && !acc; i++) begin
            @(negedge clk);
            if (req_ready) acc = 1'b1;
        end
        if (!acc) begin
            req_valid = 1'b0;
            return;
        end
        w0 = wr_count;
        @(posedge clk); #1;
        if (!hold) req_valid = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            if (resp_valid) begin
                lat = k; rd = resp_rdata; err = resp_error;
                break;
            end
        end
        req_valid = 1'b0;
        nwr = wr_count - w0;
    endtask

    task automatic test_reset();
        logic [100:0] outs;
        rst = 1'b1; req_valid = 1'b1; req_write = 1'b1; req_funct3 = 3'b010;
        req_addr = 32'h40; req_wdata = 32'hFFFF_FFFF;
        repeat (3) @(posedge clk);
        @(negedge clk);
        outs = {req_ready, resp_valid, resp_error, resp_rdata, mem_addr, mem_wr_data, mem_wr_ena};
        n_checks++;
        if (outs !== 101'h0) begin
            n_fail++;
            $display("[TB] FAIL reset_outputs got %h want 0", outs);
        end
        @(posedge clk); #1 rst = 1'b0; req_valid = 1'b0;
        @(negedge clk);
        n_checks++;
        if (req_ready !== 1'b1) begin
            n_fail++;
            $display("[TB] FAIL ready_after_reset got %b want 1", req_ready);
        end
    endtask

    task automatic test_spec_vectors();
        vec_t        q[$];
        bit          acc;
        int          lat;
        int          nwr;
        logic [31:0] rd;
        logic        err;
        ref_mem[4] = 32'h8899_AABB;
        ref_mem[8] = 32'h1122_3344;
        load_memory();
        q.push_back('{1'b0, 3'b000, 32'h11, 32'h0, 2, 32'hFFFF_FFAA, 1'b0, 0, "lb_0x11"});
        q.push_back('{1'b0, 3'b100, 32'h11, 32'h0, 2, 32'h0000_00AA, 1'b0, 0, "lbu_0x11"});
        q.push_back('{1'b1, 3'b001, 32'h22, 32'hDEAD_BEEF, 4, 32'h0, 1'b0, 1, "sh_0x22"});
        q.push_back('{1'b0, 3'b010, 32'h20, 32'h0, 2, 32'hBEEF_3344, 1'b0, 0, "lw_0x20"});
`ifdef LSU_ALIGN_CHECK_EN
        q.push_back('{1'b0, 3'b010, 32'h13, 32'h0, 1, 32'h0, 1'b1, 0, "lw_0x13"});
`else
        q.push_back('{1'b0, 3'b010, 32'h13, 32'h0, 2, 32'h8899_AABB, 1'b0, 0, "lw_0x13"});
`endif
        q.push_back('{1'b0, 3'b111, 32'h10, 32'h0, 1, 32'h0, 1'b1, 0, "load_f3_111"});
        q.push_back('{1'b1, 3'b011, 32'h10, 32'h5555_5555, 1, 32'h0, 1'b1, 0, "store_f3_011"});
        foreach (q[i]) begin
            issue(q[i].wr, q[i].f3, q[i].a, q[i].wd, 1'b0, acc, lat, rd, err, nwr);
            n_checks++;
            if (!acc || lat != q[i].elat) begin
                n_fail++;
                $display("[TB] FAIL %s latency got %0d (accepted %0b) want %0d", q[i].name, lat, acc, q[i].elat);
            end
            n_checks++;
            if (rd !== q[i].erd || err !== q[i].eerr) begin
                n_fail++;
                $display("[TB] FAIL %s resp got rdata=%h err=%b want rdata=%h err=%b", q[i].name, rd, err, q[i].erd, q[i].eerr);
            end
            n_checks++;
            if (nwr != q[i].enwr) begin
                n_fail++;
                $display("[TB] FAIL %s writes got %0d want %0d", q[i].name, nwr, q[i].enwr);
            end
        end
        n_checks++;
        if (mem[8] !== 32'hBEEF_3344) begin
            n_fail++;
            $display("[TB] FAIL sh_merge_word got %h want beef3344", mem[8]);
        end
        ref_mem[8] = 32'hBEEF_3344;
    endtask

    task automatic test_busy_hold();
        bit          acc;
        int          lat;
        int          nwr;
        int          a0;
        logic [31:0] rd;
        logic        err;
        a0 = accepts;
        issue(1'b0, 3'b010, 32'h10, 32'h0, 1'b1, acc, lat, rd, err, nwr);
        @(negedge clk);
        n_checks++;
        if (accepts - a0 != 1 || lat != 2) begin
            n_fail++;
            $display("[TB] FAIL busy_hold_lw accepts got %0d lat %0d want 1 lat 2", accepts - a0, lat);
        end
        a0 = accepts;
        issue(1'b0, 3'b111, 32'h10, 32'h0, 1'b1, acc, lat, rd, err, nwr);
        @(negedge clk);
        n_checks++;
        if (accepts - a0 != 1 || lat != 1 || err !== 1'b1) begin
            n_fail++;
            $display("[TB] FAIL busy_hold_illegal accepts got %0d lat %0d err %b want 1 1 1", accepts - a0, lat, err);
        end
    endtask

    task automatic test_back_to_back();
        bit          acc;
        int          lat;
        int          elat;
        int          nwr;
        int          enwr;
        logic [31:0] rd;
        logic [31:0] erd;
        logic        err;
        logic        eerr;
        logic [31:0] a;
        logic [31:0] wd;
        logic [2:0]  sf3;
        logic [2:0]  lf3;
        for (int n = 0; n < 12; n++) begin
            a   = $urandom_range(0, 1023);
            wd  = $urandom;
            sf3 = 3'($urandom_range(0, 2));
            a   = (sf3 == 3'b010) ? (a & ~32'h3) : (sf3 == 3'b001) ? (a & ~32'h1) : a;
            model(1'b1, sf3, a, wd, elat, erd, eerr, enwr);
            issue(1'b1, sf3, a, wd, 1'b0, acc, lat, rd, err, nwr);
            lf3 = (sf3 == 3'b010) ? 3'b010 : {1'b1, sf3[1:0]};
            model(1'b0, lf3, a, 32'h0, elat, erd, eerr, enwr);
            issue(1'b0, lf3, a, 32'h0, 1'b0, acc, lat, rd, err, nwr);
            n_checks++;
            if (lat != elat || rd !== erd || err !== eerr) begin
                n_fail++;
                $display("[TB] FAIL store_then_load a=%h got rd=%h err=%b lat=%0d want rd=%h err=%b lat=%0d",
                         a, rd, err, lat, erd, eerr, elat);
            end
        end
    endtask

    task automatic test_random();
        bit          acc;
        int          lat;
        int          elat;
        int          nwr;
        int          enwr;
        logic [31:0] rd;
        logic [31:0] erd;
        logic        err;
        logic        eerr;
        logic        wr;
        logic [2:0]  f3;
        logic [31:0] a;
        logic [31:0] wd;
        for (int n = 0; n < 80; n++) begin
            wr = 1'($urandom_range(0, 1));
            f3 = 3'($urandom_range(0, 7));
            a  = $urandom_range(0, 1023);
            wd = $urandom;
            model(wr, f3, a, wd, elat, erd, eerr, enwr);
            issue(wr, f3, a, wd, 1'b0, acc, lat, rd, err, nwr);
            n_checks++;
            if (!acc || lat != elat || rd !== erd || err !== eerr || nwr != enwr) begin
                n_fail++;
                $display("[TB] FAIL random wr=%b f3=%0d a=%h got lat=%0d rd=%h err=%b nwr=%0d want lat=%0d rd=%h err=%b nwr=%0d",
                         wr, f3, a, lat, rd, err, nwr, elat, erd, eerr, enwr);
            end
            n_checks++;
            if (mem[a[9:2]] !== ref_mem[a[9:2]]) begin
                n_fail++;
                $display("[TB] FAIL random_mem a=%h got %h want %h", a, mem[a[9:2]], ref_mem[a[9:2]]);
            end
        end
    endtask

    task automatic test_reset_during_write();
        bit acc;
        bit saw_resp;
        int w0;
        ref_mem[12] = 32'hCAFE_F00D;
        load_memory();
        @(posedge clk); #1;
        req_write = 1'b1; req_funct3 = 3'b010; req_addr = 32'h30; req_wdata = 32'h1234_5678; req_valid = 1'b1;
        @(negedge clk);
        acc = req_ready;
        @(posedge clk); #1 req_valid = 1'b0; rst = 1'b1;
        w0 = wr_count;
        @(negedge clk);
        n_checks++;
        if (!acc || mem_wr_ena !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL abort_wr_ena got %b (accepted %0b) want 0", mem_wr_ena, acc);
        end
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        n_checks++;
        if (req_ready !== 1'b1) begin
            n_fail++;
            $display("[TB] FAIL abort_ready got %b want 1", req_ready);
        end
        saw_resp = resp_valid;
        repeat (3) begin
            @(negedge clk);
            saw_resp = saw_resp | resp_valid;
        end
        n_checks++;
        if (saw_resp || mem[12] !== 32'hCAFE_F00D || wr_count != w0) begin
            n_fail++;
            $display("[TB] FAIL abort_effects got resp=%b mem=%h writes=%0d want resp=0 mem=cafef00d writes=0",
                     saw_resp, mem[12], wr_count - w0);
        end
    endtask

    initial begin
        rst = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_funct3 = 3'b000;
        req_addr = 32'h0; req_wdata = 32'h0;
        for (int i = 0; i < 256; i++) ref_mem[i] = $urandom;
        load_memory();
        test_reset();
        test_spec_vectors();
        test_busy_hold();
        test_back_to_back();
        test_random();
        test_reset_during_write();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
